// File: rtl/jelly_denorm_to_float.sv
// Converts a scaled signed fixed-point value (fixed * 2^(exp-bias-frac)) into a
// packed IEEE-style float through a 4-stage pipeline; zero/underflow flush, overflow saturates.
module jelly_denorm_to_float #(
    parameter int S_DENORM_EXP_WIDTH   = 8,
    parameter int S_DENORM_EXP_OFFSET  = (1 << (S_DENORM_EXP_WIDTH - 1)) - 1,
    parameter int S_DENORM_INT_WIDTH   = 40,
    parameter int S_DENORM_FRAC_WIDTH  = 8,
    parameter int S_DENORM_FIXED_WIDTH = S_DENORM_INT_WIDTH + S_DENORM_FRAC_WIDTH,
    parameter int M_FLOAT_EXP_WIDTH    = 8,
    parameter int M_FLOAT_EXP_OFFSET   = (1 << (M_FLOAT_EXP_WIDTH - 1)) - 1,
    parameter int M_FLOAT_FRAC_WIDTH   = 23,
    parameter int M_FLOAT_WIDTH        = 1 + M_FLOAT_EXP_WIDTH + M_FLOAT_FRAC_WIDTH,
    parameter int USER_WIDTH           = 0,
    parameter int USER_BITS            = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cke,

    input  logic [USER_BITS-1:0]            s_user,
    input  logic [S_DENORM_EXP_WIDTH-1:0]   s_denorm_exp,
    input  logic [S_DENORM_FIXED_WIDTH-1:0] s_denorm_fixed,
    input  logic                            s_valid,
    output logic                            s_ready,

    output logic [USER_BITS-1:0]            m_user,
    output logic [M_FLOAT_WIDTH-1:0]        m_float,
    output logic                            m_valid,
    input  logic                            m_ready
);

    localparam int W      = S_DENORM_FIXED_WIDTH;
    localparam int PW     = (W > 1) ? $clog2(W) : 1;
    localparam int MAX_EW = (S_DENORM_EXP_WIDTH > M_FLOAT_EXP_WIDTH) ? S_DENORM_EXP_WIDTH : M_FLOAT_EXP_WIDTH;
    localparam int EW     = MAX_EW + PW + 2;
    localparam int FW     = M_FLOAT_FRAC_WIDTH;
    localparam int XW     = M_FLOAT_EXP_WIDTH;

    // Constant part of the output exponent: output bias minus input bias minus fraction scaling
    localparam logic signed [EW-1:0] EXP_ADJ = EW'(M_FLOAT_EXP_OFFSET - S_DENORM_EXP_OFFSET - S_DENORM_FRAC_WIDTH);
    localparam logic signed [EW-1:0] EXP_SAT = EW'((1 << XW) - 1);
    localparam logic [PW-1:0]        TOP_POS = PW'(W - 1);

    function automatic logic [W-1:0] abs_mag(input logic [W-1:0] v);
        // Two's complement negate; the most-negative value maps onto 2^(W-1) unsigned
        return v[W-1] ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [PW-1:0] lead_one(input logic [W-1:0] v);
        logic [PW-1:0] pos;
        pos = '0;
        for (int i = 0; i < W; i++) begin
            pos = v[i] ? PW'(i) : pos;
        end
        return pos;
    endfunction

    logic en_s;

    logic                          st0_valid_r;
    logic                          st0_sign_r;
    logic [W-1:0]                  st0_mag_r;
    logic [S_DENORM_EXP_WIDTH-1:0] st0_exp_r;
    logic [USER_BITS-1:0]          st0_user_r;

    logic                          st1_valid_r;
    logic                          st1_sign_r;
    logic                          st1_zero_r;
    logic [W-1:0]                  st1_mag_r;
    logic [PW-1:0]                 st1_pos_r;
    logic [S_DENORM_EXP_WIDTH-1:0] st1_exp_r;
    logic [USER_BITS-1:0]          st1_user_r;

    logic                          st2_valid_r;
    logic                          st2_sign_r;
    logic                          st2_zero_r;
    logic signed [EW-1:0]          st2_exp_r;
    logic [FW-1:0]                 st2_frac_r;
    logic [USER_BITS-1:0]          st2_user_r;

    logic                          st3_valid_r;
    logic [M_FLOAT_WIDTH-1:0]      st3_float_r;
    logic [USER_BITS-1:0]          st3_user_r;

    logic [PW-1:0]                 shift_s;
    logic [W+FW-1:0]               wide_s;
    logic [FW-1:0]                 frac_s;
    logic signed [EW-1:0]          exp_s;
    logic [M_FLOAT_WIDTH-1:0]      pack_s;

    assign en_s    = cke & (~st3_valid_r | m_ready);
    assign s_ready = en_s;

    // Stage 0: split sign and magnitude
    always_ff @(posedge clk) begin
        if (reset) begin
            st0_valid_r <= 1'b0;
            st0_sign_r  <= 1'b0;
            st0_mag_r   <= '0;
            st0_exp_r   <= '0;
            st0_user_r  <= '0;
        end else if (en_s) begin
            st0_valid_r <= s_valid;
            st0_sign_r  <= s_denorm_fixed[W-1];
            st0_mag_r   <= abs_mag(s_denorm_fixed);
            st0_exp_r   <= s_denorm_exp;
            st0_user_r  <= s_user;
        end
    end

    // Stage 1: leading-one search and zero detect
    always_ff @(posedge clk) begin
        if (reset) begin
            st1_valid_r <= 1'b0;
            st1_sign_r  <= 1'b0;
            st1_zero_r  <= 1'b0;
            st1_mag_r   <= '0;
            st1_pos_r   <= '0;
            st1_exp_r   <= '0;
            st1_user_r  <= '0;
        end else if (en_s) begin
            st1_valid_r <= st0_valid_r;
            st1_sign_r  <= st0_sign_r;
            st1_zero_r  <= (st0_mag_r == '0);
            st1_mag_r   <= st0_mag_r;
            st1_pos_r   <= lead_one(st0_mag_r);
            st1_exp_r   <= st0_exp_r;
            st1_user_r  <= st0_user_r;
        end
    end

    // Normalize: move the leading one to the top, the fraction is the next FW bits below it
    always_comb begin
        shift_s = TOP_POS - st1_pos_r;
        wide_s  = {st1_mag_r, {FW{1'b0}}} << shift_s;
        frac_s  = FW'(wide_s >> (W - 1));
        exp_s   = $signed({{(EW-S_DENORM_EXP_WIDTH){1'b0}}, st1_exp_r})
                + $signed({{(EW-PW){1'b0}}, st1_pos_r})
                + EXP_ADJ;
    end

    // Stage 2: register normalized fraction and unbiased-then-rebiased exponent
    always_ff @(posedge clk) begin
        if (reset) begin
            st2_valid_r <= 1'b0;
            st2_sign_r  <= 1'b0;
            st2_zero_r  <= 1'b0;
            st2_exp_r   <= '0;
            st2_frac_r  <= '0;
            st2_user_r  <= '0;
        end else if (en_s) begin
            st2_valid_r <= st1_valid_r;
            st2_sign_r  <= st1_sign_r;
            st2_zero_r  <= st1_zero_r;
            st2_exp_r   <= exp_s;
            st2_frac_r  <= frac_s;
            st2_user_r  <= st1_user_r;
        end
    end

    // Clamp: zero and underflow give +0, overflow saturates to the largest finite value
    always_comb begin
        pack_s = '0;
        if (st2_zero_r || st2_exp_r[EW-1] || (st2_exp_r == '0)) begin
            pack_s = '0;
        end else if (st2_exp_r >= EXP_SAT) begin
            pack_s = {st2_sign_r, {(XW-1){1'b1}}, 1'b0, {FW{1'b1}}};
        end else begin
            pack_s = {st2_sign_r, st2_exp_r[XW-1:0], st2_frac_r};
        end
    end

    // Stage 3: output register
    always_ff @(posedge clk) begin
        if (reset) begin
            st3_valid_r <= 1'b0;
            st3_float_r <= '0;
            st3_user_r  <= '0;
        end else if (en_s) begin
            st3_valid_r <= st2_valid_r;
            st3_float_r <= pack_s;
            st3_user_r  <= st2_user_r;
        end
    end

    assign m_valid = st3_valid_r;
    assign m_float = st3_float_r;
    assign m_user  = st3_user_r;

endmodule

// File: tb/tb_jelly_denorm_to_float.sv
// Self-checking bench for jelly_denorm_to_float: directed corner values plus a randomized
// stream with back-pressure and clock-enable gaps, checked against an arithmetic reference.
module tb_jelly_denorm_to_float;

    localparam int FRACW = 8;
    localparam int EBIAS = 127;

    logic        clk = 1'b0;
    logic        reset;
    logic        cke;
    logic [7:0]  s_user;
    logic [7:0]  s_denorm_exp;
    logic [47:0] s_denorm_fixed;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_user;
    logic [31:0] m_float;
    logic        m_valid;
    logic        m_ready;

    always #5 clk = ~clk;

    jelly_denorm_to_float #(.USER_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .cke            (cke),
        .s_user         (s_user),
        .s_denorm_exp   (s_denorm_exp),
        .s_denorm_fixed (s_denorm_fixed),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_user         (m_user),
        .m_float        (m_float),
        .m_valid        (m_valid),
        .m_ready        (m_ready)
    );

    typedef struct {
        logic [31:0] f;
        logic [7:0]  u;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          popped = 0;
    logic        hold_r = 1'b0;
    logic [31:0] prev_f;
    logic [7:0]  prev_u;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Value = fixed * 2^(exp - bias - FRACW), rounded toward zero into single precision
    function automatic logic [31:0] ref_float(input logic signed [47:0] fx, input int ex);
        longint v, mag, fr;
        int     p, e;
        logic   s;
        v = fx;
        if (v == 0) return 32'h0000_0000;
        s   = (v < 0);
        mag = s ? -v : v;
        p   = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = ex - EBIAS + p - FRACW + 127;
        if (e <= 0) return 32'h0000_0000;
        if (e >= 255) return {s, 8'hFE, 23'h7F_FFFF};
        fr = (p >= 23) ? (mag >> (p - 23)) : (mag << (23 - p));
        return {s, e[7:0], fr[22:0]};
    endfunction

    task automatic cycle(input logic v, input logic [47:0] fx, input logic [7:0] ex,
                         input logic [7:0] us, input logic mr, input logic ck, output logic acc);
        exp_t x;
        @(negedge clk);
        s_valid = v; s_denorm_fixed = fx; s_denorm_exp = ex; s_user = us;
        m_ready = mr; cke = ck;
        #1;
        check_val("s_ready", s_ready, cke & (~m_valid | m_ready));
        if (hold_r) begin
            check_val("hold_valid", m_valid, 1'b1);
            check_val("hold_float", m_float, prev_f);
            check_val("hold_user",  m_user,  prev_u);
        end
        if (m_valid && m_ready && cke) begin
            if (sb.size() == 0) begin
                check_val("spurious", m_valid, 1'b0);
            end else begin
                x = sb.pop_front();
                popped++;
                check_val("float", m_float, x.f);
                check_val("user",  m_user,  x.u);
            end
        end
        acc = s_valid & s_ready;
        if (acc) begin
            x.f = ref_float(s_denorm_fixed, int'(s_denorm_exp));
            x.u = s_user;
            sb.push_back(x);
        end
        hold_r = m_valid & ~(m_ready & cke);
        prev_f = m_float;
        prev_u = m_user;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; cke = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_valid", m_valid, 1'b0);
        check_val("rst_float", m_float, 32'h0);
        check_val("rst_user",  m_user,  8'h0);
        check_val("rst_ready", s_ready, cke);
        sb.delete();
        hold_r = 1'b0;
    endtask

    task automatic send_lat(input logic [47:0] fx, input logic [7:0] ex, input logic [31:0] want);
        logic acc;
        int   n;
        cycle(1'b1, fx, ex, 8'hA5, 1'b1, 1'b1, acc);
        check_val("accept", acc, 1'b1);
        n = 0;
        do begin
            cycle(1'b0, 48'h0, 8'h0, 8'h0, 1'b1, 1'b1, acc);
            n++;
        end while (!m_valid && n < 20);
        check_val("latency", n, 4);
        check_val("direct",  m_float, want);
    endtask

    initial begin
        logic        acc;
        logic [63:0] r;
        logic [47:0] fx;
        int          idx, base;
        reset = 1'b1; cke = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        s_user = 8'h0; s_denorm_exp = 8'h0; s_denorm_fixed = 48'h0;
        do_reset();

        send_lat(48'd256,              8'd127, 32'h3F80_0000);
        send_lat(-48'sd768,            8'd127, 32'hC040_0000);
        send_lat(48'd256,              8'd128, 32'h4000_0000);
        send_lat(48'd0,                8'd200, 32'h0000_0000);
        send_lat(48'd1,                8'd0,   32'h0000_0000);
        // -2^47 * 2^-8 = -2^39: sign 1, biased exponent 166
        send_lat(48'h8000_0000_0000,   8'd127, 32'hD300_0000);
        send_lat(48'h7FFF_FFFF_FFFF,   8'd255, 32'h7F7F_FFFF);
        send_lat(48'h8000_0000_0001,   8'd255, 32'hFF7F_FFFF);

        // Back-pressure: 8 tagged beats, sink stalled for cycles 5..9
        idx  = 0;
        base = popped;
        for (int c = 0; c < 30; c++) begin
            cycle(idx < 8, 48'(256 * (idx + 1)), 8'd127, 8'(idx), !(c >= 5 && c <= 9), 1'b1, acc);
            if (c == 7) check_val("bp_sready", s_ready, 1'b0);
            if (acc) idx++;
        end
        check_val("bp_sent",     idx, 8);
        check_val("bp_received", popped - base, 8);
        check_val("bp_pending",  sb.size(), 0);

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) cycle(1'b1, 48'd512, 8'd127, 8'(i), 1'b1, 1'b1, acc);
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 48'h0, 8'h0, 8'h0, 1'b1, 1'b1, acc);
        send_lat(48'd256, 8'd127, 32'h3F80_0000);

        // Randomized stream with random stalls and clock-enable gaps
        for (int c = 0; c < 3000; c++) begin
            r  = {$urandom, $urandom};
            fx = $signed(r[47:0]) >>> $urandom_range(0, 47);
            if ($urandom_range(0, 15) == 0) fx = 48'h0;
            cycle($urandom_range(0, 3) != 0, fx, 8'($urandom_range(0, 255)), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, acc);
        end
        for (int c = 0; c < 50 && sb.size() != 0; c++) begin
            cycle(1'b0, 48'h0, 8'h0, 8'h0, 1'b1, 1'b1, acc);
        end
        check_val("drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
